// File: rtl/usb_audio_i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usb_audio_i2s_pkg
// Brief   : Shared types and frame constants for the USB audio to I2S bridge.
// Revision: 1.0
// ============================================================================
package usb_audio_i2s_pkg;

    localparam int BITS_PER_FRAME = 64;
    localparam int DATA_BITS      = 16;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } stereo_t;

    typedef enum logic [0:0] {
        PREFILL = 1'b0,
        RUN     = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module  : audio_sample_fifo
// Brief   : First-word-fall-through FIFO of stereo samples with level output.
// Revision: 1.0
// ============================================================================
module audio_sample_fifo
    import usb_audio_i2s_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  stereo_t          i_wr_data,
    input  logic             i_rd_en,
    output stereo_t          o_rd_data,
    output logic [FIFO_AW:0] o_level
);

    localparam int               c_DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] c_LVL_FULL = (FIFO_AW + 1)'(c_DEPTH);

    stereo_t            r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               w_push;
    logic               w_pop;

    // Full/empty are judged on the level before this cycle's update.
    assign w_push = i_wr_en && (r_level != c_LVL_FULL);
    assign w_pop  = i_rd_en && (r_level != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

endmodule
`default_nettype wire

// File: rtl/usb_audio_i2s_bridge.sv
`default_nettype none
// ============================================================================
// Module  : usb_audio_i2s_bridge
// Brief   : Buffers USB speaker samples onto an NCO-paced I2S codec link and
//           returns deserialised ADC samples to the USB audio core.
// Revision: 1.0
// ============================================================================
module usb_audio_i2s_bridge #(
    parameter int          FIFO_AW   = 4,
    parameter logic [31:0] PHASE_INC = 32'd439804651,
    parameter int          PREFILL   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             audio_en,
    input  logic [15:0]      audio_lo,
    input  logic [15:0]      audio_ro,
    output logic [15:0]      audio_li,
    output logic [15:0]      audio_ri,
    output logic             i2s_bclk,
    output logic             i2s_lrck,
    output logic             i2s_dout,
    input  logic             i2s_din,
    output logic [FIFO_AW:0] fifo_level,
    output logic             ovf,
    output logic             udf,
    input  logic             clr_flags
);
    import usb_audio_i2s_pkg::*;

    localparam int               c_DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] c_LVL_FULL  = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [FIFO_AW:0] c_LVL_START = (FIFO_AW + 1)'(PREFILL);
    localparam logic [4:0]       c_LAST_SLOT = 5'(DATA_BITS);
    localparam logic [5:0]       c_LAST_BIT  = 6'(BITS_PER_FRAME - 1);

    logic [31:0]      r_acc;
    logic             r_bclk;
    logic             r_lrck;
    logic             r_dout;
    logic [5:0]       r_bitcnt;
    sched_state_t     r_state;
    stereo_t          r_tx;
    stereo_t          r_rx;
    logic [15:0]      r_audio_li;
    logic [15:0]      r_audio_ri;
    logic [1:0]       r_din_sync;
    logic             r_ovf;
    logic             r_udf;

    logic [31:0]      w_acc_sum;
    logic             w_carry;
    logic             w_fall;
    logic             w_rise;
    logic             w_frame_start;
    logic [5:0]       w_bc_nxt;
    logic [4:0]       w_slot_nxt;
    logic             w_tx_act;
    logic             w_rx_act;
    logic [3:0]       w_tx_idx;
    logic [15:0]      w_tx_word;
    logic             w_tx_bit;
    logic [FIFO_AW:0] w_level;
    logic             w_empty;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_udf_set;
    stereo_t          w_head;

    assign {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, PHASE_INC};
    assign w_fall        = w_carry && r_bclk;
    assign w_rise        = w_carry && !r_bclk;
    assign w_frame_start = w_fall && (r_bitcnt == c_LAST_BIT);

    // Transmit bits are selected for the slot being entered on this fall.
    assign w_bc_nxt   = r_bitcnt + 6'd1;
    assign w_slot_nxt = w_bc_nxt[4:0];
    assign w_tx_act   = (w_slot_nxt != 5'd0) && (w_slot_nxt <= c_LAST_SLOT);
    assign w_tx_idx   = 4'(c_LAST_SLOT - w_slot_nxt);
    assign w_tx_word  = w_bc_nxt[5] ? r_tx.r : r_tx.l;
    assign w_tx_bit   = w_tx_act && w_tx_word[w_tx_idx];

    assign w_rx_act   = (r_bitcnt[4:0] != 5'd0) && (r_bitcnt[4:0] <= c_LAST_SLOT);

    assign w_empty    = (w_level == '0);
    assign w_pop      = w_frame_start &&
                        ((r_state == usb_audio_i2s_pkg::RUN) ? !w_empty : (w_level >= c_LVL_START));
    assign w_ovf_set  = audio_en && (w_level == c_LVL_FULL);
    assign w_udf_set  = w_frame_start && (r_state == usb_audio_i2s_pkg::RUN) && w_empty;

    audio_sample_fifo #(
        .FIFO_AW   (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (audio_en),
        .i_wr_data ({audio_lo, audio_ro}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_level   (w_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_bclk   <= 1'b0;
            r_lrck   <= 1'b0;
            r_dout   <= 1'b0;
            r_bitcnt <= c_LAST_BIT;
            r_state  <= usb_audio_i2s_pkg::PREFILL;
            r_tx     <= '0;
        end else begin
            r_acc <= w_acc_sum;
            if (w_carry) r_bclk <= ~r_bclk;
            if (w_fall) begin
                r_bitcnt <= w_bc_nxt;
                r_lrck   <= w_bc_nxt[5];
                r_dout   <= w_tx_bit;
            end
            if (w_frame_start) begin
                if (w_pop) begin
                    r_tx    <= w_head;
                    r_state <= usb_audio_i2s_pkg::RUN;
                end else begin
                    // Starved or still filling: send silence and wait for a full prefill.
                    r_tx    <= '0;
                    r_state <= usb_audio_i2s_pkg::PREFILL;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_sync <= '0;
            r_rx       <= '0;
            r_audio_li <= '0;
            r_audio_ri <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_din_sync <= {r_din_sync[0], i2s_din};
            if (w_rise && w_rx_act) begin
                if (r_bitcnt[5]) r_rx.r <= {r_rx.r[14:0], r_din_sync[1]};
                else             r_rx.l <= {r_rx.l[14:0], r_din_sync[1]};
            end
            if (w_frame_start) begin
                r_audio_li <= r_rx.l;
                r_audio_ri <= r_rx.r;
            end
            r_ovf <= w_ovf_set || (r_ovf && !clr_flags);
            r_udf <= w_udf_set || (r_udf && !clr_flags);
        end
    end

    assign audio_li   = r_audio_li;
    assign audio_ri   = r_audio_ri;
    assign i2s_bclk   = r_bclk;
    assign i2s_lrck   = r_lrck;
    assign i2s_dout   = r_dout;
    assign fifo_level = w_level;
    assign ovf        = r_ovf;
    assign udf        = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_usb_audio_i2s_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_usb_audio_i2s_bridge
// Brief   : Directed self-checking bench for usb_audio_i2s_bridge, DAC looped to ADC.
// Revision: 1.0
// ============================================================================
module tb_usb_audio_i2s_bridge;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        audio_en  = 1'b0;
    logic        clr_flags = 1'b0;
    logic [15:0] audio_lo  = '0;
    logic [15:0] audio_ro  = '0;
    logic [15:0] audio_li;
    logic [15:0] audio_ri;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_dout;
    logic        i2s_din;
    logic [4:0]  fifo_level;
    logic        ovf;
    logic        udf;

    assign i2s_din = i2s_dout;

    usb_audio_i2s_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .audio_en   (audio_en),
        .audio_lo   (audio_lo),
        .audio_ro   (audio_ro),
        .audio_li   (audio_li),
        .audio_ri   (audio_ri),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_dout   (i2s_dout),
        .i2s_din    (i2s_din),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .udf        (udf),
        .clr_flags  (clr_flags)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          fails     = 0;
    int          frame_cnt = 0;
    int          lrck_err  = 0;
    int          hp_cnt    = 0;
    int          hp_min    = 1000;
    int          hp_max    = 0;
    int          mon_s     = 0;
    bit          hp_valid  = 1'b0;
    logic [5:0]  tb_bc     = 6'd63;
    logic        prev_bclk = 1'b0;
    logic [15:0] cap_l     = '0;
    logic [15:0] cap_r     = '0;
    logic [15:0] last_l    = '0;
    logic [15:0] last_r    = '0;
    bit          cur_any   = 1'b0;
    bit          last_any  = 1'b0;

    // Independent frame tracker: counts BCLK falls and captures each transmitted frame.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            tb_bc     = 6'd63;
            prev_bclk = 1'b0;
            hp_valid  = 1'b0;
            hp_cnt    = 0;
            cap_l     = '0;
            cap_r     = '0;
            cur_any   = 1'b0;
        end else begin
            hp_cnt++;
            if (i2s_bclk != prev_bclk) begin
                if (hp_valid) begin
                    if (hp_cnt < hp_min) hp_min = hp_cnt;
                    if (hp_cnt > hp_max) hp_max = hp_cnt;
                end
                hp_valid = 1'b1;
                hp_cnt   = 0;
                if (prev_bclk) begin
                    tb_bc = tb_bc + 6'd1;
                    if (i2s_lrck !== tb_bc[5]) lrck_err++;
                    if (tb_bc == 6'd0) begin
                        last_l   = cap_l;
                        last_r   = cap_r;
                        last_any = cur_any;
                        cap_l    = '0;
                        cap_r    = '0;
                        cur_any  = 1'b0;
                        frame_cnt++;
                    end
                    if (i2s_dout) cur_any = 1'b1;
                    mon_s = int'(tb_bc[4:0]);
                    if (mon_s >= 1 && mon_s <= 16) begin
                        if (tb_bc[5]) cap_r[16 - mon_s] = i2s_dout;
                        else          cap_l[16 - mon_s] = i2s_dout;
                    end
                end
            end
            prev_bclk = i2s_bclk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame();
        int f0 = frame_cnt;
        int n  = 0;
        while (frame_cnt == f0 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (frame_cnt != f0) else begin
            fails++;
            $error("FAIL frame_timeout observed=%0d expected=%0d", frame_cnt, f0 + 1);
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r, input logic clr);
        audio_en  = 1'b1;
        audio_lo  = l;
        audio_ro  = r;
        clr_flags = clr;
        @(negedge clk);
        audio_en  = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    logic [31:0] exp_lr;
    int          n;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_audio_in", {audio_li, audio_ri}, 32'h0);
        check("rst_i2s_pins", {29'd0, i2s_bclk, i2s_lrck, i2s_dout}, 32'h0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_flags", {30'd0, ovf, udf}, 32'h0);
        rst = 1'b0;

        // Idle: silence, 64-BCLK frames, BCLK half-period 9 or 10 clk
        wait_frame();
        wait_frame();
        wait_frame();
        check("idle_dout_zero", 32'(last_any), 32'd0);
        check("idle_level", 32'(fifo_level), 32'd0);
        check("idle_no_udf", 32'(udf), 32'd0);
        check("lrck_period", 32'(lrck_err), 32'd0);
        check("bclk_half_min", 32'(hp_min), 32'd9);
        check("bclk_half_max", 32'(hp_max), 32'd10);

        // Prefill at frame rate, then RUN
        for (int i = 0; i < 8; i++) begin
            push(16'h8001, 16'h7FFE, 1'b0);
            if (i < 7) wait_frame();
        end
        check("prefill_level8", 32'(fifo_level), 32'd8);
        wait_frame();
        check("run_first_pop", 32'(fifo_level), 32'd7);
        wait_frame();
        check("tx_frame_lr", {last_l, last_r}, 32'h8001_7FFE);
        check("loop_rx_lr", {audio_li, audio_ri}, 32'h8001_7FFE);
        check("run_level", 32'(fifo_level), 32'd6);

        // Overflow: fill to 16, drop the 17th, set beats clear
        for (int i = 0; i < 10; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0);
        check("full_level", 32'(fifo_level), 32'd16);
        check("no_ovf_yet", 32'(ovf), 32'd0);
        push(16'hDEAD, 16'hDEAD, 1'b0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd16);
        push(16'hBEEF, 16'hBEEF, 1'b1);
        check("ovf_set_wins", 32'(ovf), 32'd1);
        check("ovf_level2", 32'(fifo_level), 32'd16);
        pulse_clr();
        check("ovf_clr", 32'(ovf), 32'd0);

        // Drain in order, then underflow into a silent frame
        wait_frame();
        for (int k = 1; k <= 16; k++) begin
            wait_frame();
            exp_lr = (k <= 6) ? 32'h8001_7FFE : {16'h1000 + 16'(k - 7), 16'h2000 + 16'(k - 7)};
            check("drain_tx", {last_l, last_r}, exp_lr);
            check("drain_rx", {audio_li, audio_ri}, exp_lr);
        end
        check("udf_set", 32'(udf), 32'd1);
        check("drained_level", 32'(fifo_level), 32'd0);
        wait_frame();
        check("udf_zero_frame", {last_l, last_r}, 32'h0);
        check("udf_zero_any", 32'(last_any), 32'd0);
        check("udf_rx_zero", {audio_li, audio_ri}, 32'h0);
        pulse_clr();
        check("udf_clr", 32'(udf), 32'd0);

        // Back in PREFILL: 7 samples must not be popped
        for (int i = 0; i < 7; i++) push(16'h1234, 16'hABCD, 1'b0);
        check("prefill7", 32'(fifo_level), 32'd7);
        wait_frame();
        wait_frame();
        check("prefill_hold", 32'(fifo_level), 32'd7);
        check("prefill_silent", 32'(last_any), 32'd0);
        check("prefill_no_udf", 32'(udf), 32'd0);
        push(16'h1234, 16'hABCD, 1'b0);
        check("prefill_level8b", 32'(fifo_level), 32'd8);
        wait_frame();
        check("rerun_pop", 32'(fifo_level), 32'd7);
        wait_frame();
        check("loop_tx", {last_l, last_r}, 32'h1234_ABCD);
        check("loop_rx_li", 32'(audio_li), 32'h1234);
        check("loop_rx_ri", 32'(audio_ri), 32'hABCD);

        // Asynchronous reset in the right channel
        n = 0;
        while (tb_bc < 6'd40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_lrck", 32'(i2s_lrck), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_audio_in", {audio_li, audio_ri}, 32'h0);
        check("mid_rst_i2s_pins", {29'd0, i2s_bclk, i2s_lrck, i2s_dout}, 32'h0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_flags", {30'd0, ovf, udf}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_frame();
        check("post_rst_lrck", 32'(i2s_lrck), 32'd0);
        check("post_rst_level", 32'(fifo_level), 32'd0);
        wait_frame();
        check("post_rst_silent", 32'(last_any), 32'd0);
        check("post_rst_rx", {audio_li, audio_ri}, 32'h0);
        check("post_rst_no_udf", 32'(udf), 32'd0);
        check("lrck_period_all", 32'(lrck_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
